// File: rtl/error_scoreboard.sv
// In-order result checker: references queue in a circular FIFO and each measurement
// is judged against the oldest one, with tolerance, counters and first-error capture.
module error_scoreboard #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNTWIDTH  = 16,
    parameter int unsigned TOLERANCE = 0,
    parameter int unsigned SIGNED    = 0,
    parameter bit          REPORTERR = 1'b1
) (
    input  logic                       clkIn,
    input  logic                       rstIn,
    input  logic                       clearIn,
    input  logic                       enIn,
    input  logic [DATAWIDTH-1:0]       refIn,
    input  logic                       refValidIn,
    input  logic [DATAWIDTH-1:0]       measIn,
    input  logic                       measValidIn,
    output logic                       errOut,
    output logic                       errPulseOut,
    output logic [CNTWIDTH-1:0]        errCntOut,
    output logic [CNTWIDTH-1:0]        matchCntOut,
    output logic [DATAWIDTH-1:0]       firstErrMeasOut,
    output logic [DATAWIDTH-1:0]       firstErrRefOut,
    output logic [CNTWIDTH-1:0]        firstErrIdxOut,
    output logic [$clog2(DEPTH):0]     levelOut,
    output logic                       emptyOut,
    output logic                       fullOut,
    output logic                       ovfOut,
    output logic                       unfOut
);

    localparam int                    AW      = $clog2(DEPTH);
    localparam int                    LW      = AW + 1;
    localparam bit                    SGN     = (SIGNED != 0);
    localparam logic [DATAWIDTH:0]    TOL     = (DATAWIDTH + 1)'(TOLERANCE);
    localparam logic [LW-1:0]         LVLFULL = LW'(DEPTH);
    localparam logic [CNTWIDTH-1:0]   CNTMAX  = '1;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    logic [CNTWIDTH-1:0]  idxP1;

    logic [DATAWIDTH-1:0] headP0;
    logic                 doPushP0;
    logic                 doPopP0;
    logic                 judgeP0;
    logic                 hasXP0;
    logic                 failP0;
    logic                 passP0;
    logic                 ovfSetP0;
    logic                 unfSetP0;
    logic [LW-1:0]        levelNextP0;

    // Extending by one bit before subtracting keeps the difference exact for any operands.
    function automatic logic [DATAWIDTH:0] absDiff(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
        logic signed [DATAWIDTH:0] ax;
        logic signed [DATAWIDTH:0] bx;
        logic signed [DATAWIDTH:0] d;
        ax = $signed({SGN & a[DATAWIDTH-1], a});
        bx = $signed({SGN & b[DATAWIDTH-1], b});
        d  = ax - bx;
        if (d < 0) absDiff = $unsigned(-d);
        else       absDiff = $unsigned(d);
    endfunction

    assign headP0 = mem[rdPtr];

`ifndef SYNTHESIS
    assign hasXP0 = $isunknown(measIn) || $isunknown(headP0);
`else
    assign hasXP0 = 1'b0;
`endif

    // Stage 0: decide push/pop and judge the head entry combinationally
    always_comb begin
        doPopP0     = measValidIn && !emptyOut;
        doPushP0    = refValidIn && (!fullOut || doPopP0);
        judgeP0     = doPopP0 && enIn;
        failP0      = judgeP0 && (hasXP0 || (absDiff(measIn, headP0) > TOL));
        passP0      = judgeP0 && !failP0;
        ovfSetP0    = refValidIn && fullOut && !doPopP0;
        unfSetP0    = measValidIn && emptyOut;
        levelNextP0 = levelOut + LW'(doPushP0) - LW'(doPopP0);
    end

    // Stage 1: FIFO pointers and occupancy
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            levelOut <= '0;
            emptyOut <= 1'b1;
            fullOut  <= 1'b0;
        end else begin
            if (doPushP0) wrPtr <= wrPtr + AW'(1);
            if (doPopP0)  rdPtr <= rdPtr + AW'(1);
            levelOut <= levelNextP0;
            emptyOut <= (levelNextP0 == '0);
            fullOut  <= (levelNextP0 == LVLFULL);
        end
    end

    always_ff @(posedge clkIn) begin
        if (doPushP0) mem[wrPtr] <= refIn;
    end

    // Stage 1: verdict, counters, sticky flags and first-failure capture
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            errOut          <= 1'b0;
            errPulseOut     <= 1'b0;
            errCntOut       <= '0;
            matchCntOut     <= '0;
            idxP1           <= '0;
            firstErrMeasOut <= '0;
            firstErrRefOut  <= '0;
            firstErrIdxOut  <= '0;
            ovfOut          <= 1'b0;
            unfOut          <= 1'b0;
        end else if (clearIn) begin
            errOut          <= 1'b0;
            errPulseOut     <= 1'b0;
            errCntOut       <= '0;
            matchCntOut     <= '0;
            idxP1           <= '0;
            firstErrMeasOut <= '0;
            firstErrRefOut  <= '0;
            firstErrIdxOut  <= '0;
            ovfOut          <= 1'b0;
            unfOut          <= 1'b0;
        end else begin
            errPulseOut <= failP0;
            if (failP0) begin
                errOut <= 1'b1;
                if (errCntOut != CNTMAX) errCntOut <= errCntOut + CNTWIDTH'(1);
                if (!errOut) begin
                    firstErrMeasOut <= measIn;
                    firstErrRefOut  <= headP0;
                    firstErrIdxOut  <= idxP1;
                end
            end
            if (passP0 && (matchCntOut != CNTMAX)) matchCntOut <= matchCntOut + CNTWIDTH'(1);
            if (judgeP0 && (idxP1 != CNTMAX))      idxP1 <= idxP1 + CNTWIDTH'(1);
            if (ovfSetP0) ovfOut <= 1'b1;
            if (unfSetP0) unfOut <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clkIn) begin
        if (REPORTERR && rstIn && !clearIn && failP0)
            $error("error_scoreboard: t=%0t idx=%0d meas=%h ref=%h", $time, idxP1, measIn, headP0);
    end
`endif

endmodule

// File: tb/tb_error_scoreboard.sv
// Directed bench for error_scoreboard: an exact-match instance and a signed tolerance instance.
module tb_error_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstN;

    logic        clrA, enA, rvA, mvA;
    logic [7:0]  refA, measA;
    logic        errA, pulA, emptyA, fullA, ovfA, unfA;
    logic [15:0] eCntA, mCntA, fIdxA;
    logic [7:0]  fMeasA, fRefA;
    logic [2:0]  lvlA;

    logic        clrT, enT, rvT, mvT;
    logic [7:0]  refT, measT;
    logic        errT, pulT, emptyT, fullT, ovfT, unfT;
    logic [2:0]  eCntT, mCntT, fIdxT;
    logic [7:0]  fMeasT, fRefT;
    logic [2:0]  lvlT;

    int checks = 0;
    int failures = 0;

    error_scoreboard #(.DATAWIDTH(8), .DEPTH(4), .CNTWIDTH(16), .TOLERANCE(0), .SIGNED(0), .REPORTERR(1'b0)) uA (
        .clkIn(clk), .rstIn(rstN), .clearIn(clrA), .enIn(enA),
        .refIn(refA), .refValidIn(rvA), .measIn(measA), .measValidIn(mvA),
        .errOut(errA), .errPulseOut(pulA), .errCntOut(eCntA), .matchCntOut(mCntA),
        .firstErrMeasOut(fMeasA), .firstErrRefOut(fRefA), .firstErrIdxOut(fIdxA),
        .levelOut(lvlA), .emptyOut(emptyA), .fullOut(fullA), .ovfOut(ovfA), .unfOut(unfA));

    error_scoreboard #(.DATAWIDTH(8), .DEPTH(4), .CNTWIDTH(3), .TOLERANCE(2), .SIGNED(1), .REPORTERR(1'b0)) uT (
        .clkIn(clk), .rstIn(rstN), .clearIn(clrT), .enIn(enT),
        .refIn(refT), .refValidIn(rvT), .measIn(measT), .measValidIn(mvT),
        .errOut(errT), .errPulseOut(pulT), .errCntOut(eCntT), .matchCntOut(mCntT),
        .firstErrMeasOut(fMeasT), .firstErrRefOut(fRefT), .firstErrIdxOut(fIdxT),
        .levelOut(lvlT), .emptyOut(emptyT), .fullOut(fullT), .ovfOut(ovfT), .unfOut(unfT));

    task automatic stepA(input logic rv, input logic [7:0] r, input logic mv, input logic [7:0] m);
        rvA = rv; refA = r; mvA = mv; measA = m;
        @(posedge clk); #1;
        rvA = 1'b0; mvA = 1'b0;
    endtask

    task automatic stepT(input logic rv, input logic [7:0] r, input logic mv, input logic [7:0] m);
        rvT = rv; refT = r; mvT = mv; measT = m;
        @(posedge clk); #1;
        rvT = 1'b0; mvT = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (emptyA !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0d exp=1", emptyA); end
        checks++; if (lvlA !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", lvlA); end
        checks++; if ({errA, pulA, fullA, ovfA, unfA} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {errA, pulA, fullA, ovfA, unfA}); end
        checks++; if ({eCntA, mCntA, fIdxA, fMeasA, fRefA} !== '0) begin failures++; $display("FAIL rst_regs got=%h exp=0", {eCntA, mCntA, fIdxA, fMeasA, fRefA}); end
        rstN = 1'b1;
    endtask

    task automatic test_latency;
        stepA(1, 8'd10, 0, 8'd0);
        stepA(1, 8'd20, 0, 8'd0);
        stepA(1, 8'd30, 0, 8'd0);
        checks++; if (lvlA !== 3'd3) begin failures++; $display("FAIL lat_level got=%0d exp=3", lvlA); end
        stepA(0, 8'd0, 1, 8'd10);
        stepA(0, 8'd0, 1, 8'd20);
        stepA(0, 8'd0, 1, 8'd30);
        checks++; if (mCntA !== 16'd3) begin failures++; $display("FAIL lat_match got=%0d exp=3", mCntA); end
        checks++; if (errA !== 1'b0) begin failures++; $display("FAIL lat_err got=%0d exp=0", errA); end
        checks++; if (emptyA !== 1'b1) begin failures++; $display("FAIL lat_empty got=%0d exp=1", emptyA); end
    endtask

    task automatic test_mismatch;
        clrA = 1'b1; stepA(0, 8'd0, 0, 8'd0); clrA = 1'b0;
        stepA(1, 8'd5, 0, 8'd0);
        stepA(1, 8'd6, 0, 8'd0);
        stepA(1, 8'd7, 0, 8'd0);
        stepA(0, 8'd0, 1, 8'd5);
        checks++; if (pulA !== 1'b0) begin failures++; $display("FAIL mm_pulse1 got=%0d exp=0", pulA); end
        stepA(0, 8'd0, 1, 8'd9);
        checks++; if (pulA !== 1'b1) begin failures++; $display("FAIL mm_pulse2 got=%0d exp=1", pulA); end
        stepA(0, 8'd0, 1, 8'd8);
        checks++; if (pulA !== 1'b1) begin failures++; $display("FAIL mm_pulse3 got=%0d exp=1", pulA); end
        stepA(0, 8'd0, 0, 8'd0);
        checks++; if (pulA !== 1'b0) begin failures++; $display("FAIL mm_pulse_idle got=%0d exp=0", pulA); end
        checks++; if (eCntA !== 16'd2) begin failures++; $display("FAIL mm_errcnt got=%0d exp=2", eCntA); end
        checks++; if (mCntA !== 16'd1) begin failures++; $display("FAIL mm_match got=%0d exp=1", mCntA); end
        checks++; if (errA !== 1'b1) begin failures++; $display("FAIL mm_err got=%0d exp=1", errA); end
        checks++; if (fMeasA !== 8'd9) begin failures++; $display("FAIL mm_fmeas got=%0d exp=9", fMeasA); end
        checks++; if (fRefA !== 8'd6) begin failures++; $display("FAIL mm_fref got=%0d exp=6", fRefA); end
        checks++; if (fIdxA !== 16'd1) begin failures++; $display("FAIL mm_fidx got=%0d exp=1", fIdxA); end
    endtask

    task automatic test_clear_reset;
        stepA(1, 8'd1, 0, 8'd0);
        stepA(1, 8'd2, 0, 8'd0);
        stepA(1, 8'd3, 0, 8'd0);
        clrA = 1'b1; stepA(0, 8'd0, 0, 8'd0); clrA = 1'b0;
        checks++; if ({errA, eCntA, mCntA} !== '0) begin failures++; $display("FAIL clr_cnt got=%h exp=0", {errA, eCntA, mCntA}); end
        checks++; if ({fMeasA, fRefA, fIdxA} !== '0) begin failures++; $display("FAIL clr_capture got=%h exp=0", {fMeasA, fRefA, fIdxA}); end
        checks++; if (lvlA !== 3'd3) begin failures++; $display("FAIL clr_level got=%0d exp=3", lvlA); end
        clrA = 1'b1; stepA(0, 8'd0, 1, 8'd99); clrA = 1'b0;
        checks++; if ({errA, pulA, eCntA} !== '0) begin failures++; $display("FAIL clr_wins got=%h exp=0", {errA, pulA, eCntA}); end
        checks++; if (lvlA !== 3'd2) begin failures++; $display("FAIL clr_pop_level got=%0d exp=2", lvlA); end
        stepA(1, 8'd4, 0, 8'd0);
        @(posedge clk); #3;
        rstN = 1'b0;
        #1;
        checks++; if (lvlA !== 3'd0) begin failures++; $display("FAIL arst_level got=%0d exp=0", lvlA); end
        checks++; if (emptyA !== 1'b1) begin failures++; $display("FAIL arst_empty got=%0d exp=1", emptyA); end
        #2;
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full;
        stepA(1, 8'd11, 0, 8'd0);
        stepA(1, 8'd12, 0, 8'd0);
        stepA(1, 8'd13, 0, 8'd0);
        checks++; if (fullA !== 1'b0) begin failures++; $display("FAIL full_early got=%0d exp=0", fullA); end
        stepA(1, 8'd14, 0, 8'd0);
        checks++; if (fullA !== 1'b1) begin failures++; $display("FAIL full_set got=%0d exp=1", fullA); end
        stepA(1, 8'd15, 0, 8'd0);
        checks++; if (ovfA !== 1'b1) begin failures++; $display("FAIL full_ovf got=%0d exp=1", ovfA); end
        checks++; if (lvlA !== 3'd4) begin failures++; $display("FAIL full_ovf_level got=%0d exp=4", lvlA); end
        clrA = 1'b1; stepA(0, 8'd0, 0, 8'd0); clrA = 1'b0;
        stepA(1, 8'd21, 1, 8'd11);
        checks++; if (ovfA !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf got=%0d exp=0", ovfA); end
        checks++; if (lvlA !== 3'd4) begin failures++; $display("FAIL full_pushpop_level got=%0d exp=4", lvlA); end
        checks++; if (mCntA !== 16'd1) begin failures++; $display("FAIL full_pushpop_match got=%0d exp=1", mCntA); end
        stepA(0, 8'd0, 1, 8'd12);
        stepA(0, 8'd0, 1, 8'd13);
        stepA(0, 8'd0, 1, 8'd14);
        stepA(0, 8'd0, 1, 8'd21);
        checks++; if (mCntA !== 16'd5) begin failures++; $display("FAIL full_wrap_match got=%0d exp=5", mCntA); end
        checks++; if (eCntA !== 16'd0) begin failures++; $display("FAIL full_wrap_err got=%0d exp=0", eCntA); end
        checks++; if (emptyA !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%0d exp=1", emptyA); end
    endtask

    task automatic test_empty;
        stepA(1, 8'h42, 1, 8'h55);
        checks++; if (unfA !== 1'b1) begin failures++; $display("FAIL emp_unf got=%0d exp=1", unfA); end
        checks++; if (lvlA !== 3'd1) begin failures++; $display("FAIL emp_level got=%0d exp=1", lvlA); end
        checks++; if ({pulA, eCntA} !== '0) begin failures++; $display("FAIL emp_nocmp got=%h exp=0", {pulA, eCntA}); end
        checks++; if (mCntA !== 16'd5) begin failures++; $display("FAIL emp_match got=%0d exp=5", mCntA); end
        enA = 1'b0;
        stepA(0, 8'd0, 1, 8'h99);
        enA = 1'b1;
        checks++; if (lvlA !== 3'd0) begin failures++; $display("FAIL dis_pop_level got=%0d exp=0", lvlA); end
        checks++; if ({errA, pulA, eCntA} !== '0) begin failures++; $display("FAIL dis_nojudge got=%h exp=0", {errA, pulA, eCntA}); end
        checks++; if (mCntA !== 16'd5) begin failures++; $display("FAIL dis_match got=%0d exp=5", mCntA); end
    endtask

    task automatic test_tolerance;
        stepT(1, 8'hFF, 0, 8'h00);
        stepT(0, 8'h00, 1, 8'h01);
        checks++; if (mCntT !== 3'd1) begin failures++; $display("FAIL tol_pass got=%0d exp=1", mCntT); end
        checks++; if (pulT !== 1'b0) begin failures++; $display("FAIL tol_pass_pulse got=%0d exp=0", pulT); end
        stepT(1, 8'hFF, 0, 8'h00);
        stepT(0, 8'h00, 1, 8'h02);
        checks++; if (eCntT !== 3'd1) begin failures++; $display("FAIL tol_fail got=%0d exp=1", eCntT); end
        checks++; if (pulT !== 1'b1) begin failures++; $display("FAIL tol_fail_pulse got=%0d exp=1", pulT); end
        stepT(1, 8'h01, 0, 8'h00);
        stepT(0, 8'h00, 1, 8'hFF);
        checks++; if (mCntT !== 3'd2) begin failures++; $display("FAIL tol_neg_pass got=%0d exp=2", mCntT); end
        stepT(1, 8'h80, 0, 8'h00);
        stepT(0, 8'h00, 1, 8'h7F);
        checks++; if (eCntT !== 3'd2) begin failures++; $display("FAIL tol_span_fail got=%0d exp=2", eCntT); end
        checks++; if ({fMeasT, fRefT} !== 16'h02FF) begin failures++; $display("FAIL tol_capture got=%h exp=02ff", {fMeasT, fRefT}); end
        checks++; if (fIdxT !== 3'd1) begin failures++; $display("FAIL tol_fidx got=%0d exp=1", fIdxT); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            stepT(1, 8'h00, (i > 0), 8'h10);
            if (i == 5) begin
                checks++; if (pulT !== 1'b1) begin failures++; $display("FAIL b2b_pulse got=%0d exp=1", pulT); end
                checks++; if (lvlT !== 3'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", lvlT); end
            end
        end
        stepT(0, 8'h00, 1, 8'h10);
        checks++; if (eCntT !== 3'd7) begin failures++; $display("FAIL b2b_sat got=%0d exp=7", eCntT); end
        checks++; if (mCntT !== 3'd2) begin failures++; $display("FAIL b2b_match got=%0d exp=2", mCntT); end
        checks++; if (lvlT !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", lvlT); end
        checks++; if (fIdxT !== 3'd1) begin failures++; $display("FAIL b2b_fidx_hold got=%0d exp=1", fIdxT); end
    endtask

    initial begin
        rstN = 1'b0;
        clrA = 1'b0; enA = 1'b1; rvA = 1'b0; mvA = 1'b0; refA = '0; measA = '0;
        clrT = 1'b0; enT = 1'b1; rvT = 1'b0; mvT = 1'b0; refT = '0; measT = '0;
        test_reset;
        test_latency;
        test_mismatch;
        test_clear_reset;
        test_full;
        test_empty;
        test_tolerance;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
